// File: rtl/ysyx_25040101_csr_unit_if.sv
// Bus between the execute stage and the M-mode CSR unit: CSR access,
// trap/mret/retire events, interrupt lines and the fetch redirect.
interface ysyx_25040101_csr_unit_if;
  logic [11:0] csr_index_i;
  logic [1:0]  csr_op_i;
  logic [31:0] csr_src_i;
  logic [31:0] csr_rdata_o;
  logic        illegal_o;
  logic        exc_valid_i;
  logic [4:0]  exc_cause_i;
  logic [31:0] exc_tval_i;
  logic [31:0] pc_i;
  logic        irq_ok_i;
  logic        mret_i;
  logic        retire_i;
  logic        irq_timer_i;
  logic        irq_ext_i;
  logic        trap_o;
  logic [31:0] trap_pc_o;
  logic [31:0] mepc_o;
  logic        irq_pend_o;

  modport slave (
    input  csr_index_i, csr_op_i, csr_src_i,
    input  exc_valid_i, exc_cause_i, exc_tval_i, pc_i,
    input  irq_ok_i, mret_i, retire_i, irq_timer_i, irq_ext_i,
    output csr_rdata_o, illegal_o, trap_o, trap_pc_o, mepc_o, irq_pend_o
  );

  modport master (
    output csr_index_i, csr_op_i, csr_src_i,
    output exc_valid_i, exc_cause_i, exc_tval_i, pc_i,
    output irq_ok_i, mret_i, retire_i, irq_timer_i, irq_ext_i,
    input  csr_rdata_o, illegal_o, trap_o, trap_pc_o, mepc_o, irq_pend_o
  );
endinterface

// File: rtl/ysyx_25040101_csr_unit.sv
// M-mode CSR file: CSR read/modify/write, exception/interrupt/mret commit,
// 64-bit mcycle/minstret and a registered one-cycle fetch redirect.
module ysyx_25040101_csr_unit #(
  parameter logic [31:0] HART_ID   = 32'h0,
  parameter logic [31:0] MTVEC_RST = 32'h0,
  parameter int          CNT_EN    = 1,
  parameter int          NUM_VEC   = 16
) (
  input logic                         clk,
  input logic                         rst,
  ysyx_25040101_csr_unit_if.slave     bus
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTRETH= 12'hB82;
  localparam logic [11:0] A_MHARTID  = 12'hF14;
  localparam logic [31:0] MISA_VAL   = 32'h4000_0100;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic        r_mie_mtie;
  logic        r_mie_meie;
  logic [29:0] r_mtvec_base;
  logic        r_mtvec_vec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
  logic        r_trap;
  logic [31:0] r_trap_pc;

  logic [31:0] w_mstatus;
  logic [31:0] w_mie;
  logic [31:0] w_mip;
  logic [31:0] w_mtvec;
  logic [31:0] w_old;
  logic        w_known;
  logic        w_ro;
  logic        w_wr_req;
  logic        w_illegal;
  logic [31:0] w_wdata;
  logic        w_csr_we;
  logic        w_irq_pend;
  logic        w_exc;
  logic        w_irq_take;
  logic        w_mret;
  logic        w_trap_enter;
  logic [4:0]  w_irq_cause;
  logic [4:0]  w_cause;
  logic [31:0] w_trap_target;
  logic [63:0] w_cnt [2];

  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
  assign w_mie     = {20'b0, r_mie_meie, 3'b0, r_mie_mtie, 7'b0};
  assign w_mip     = {20'b0, bus.irq_ext_i, 3'b0, bus.irq_timer_i, 7'b0};
  assign w_mtvec   = {r_mtvec_base, 1'b0, r_mtvec_vec};

  always_comb begin
    w_old   = '0;
    w_known = 1'b1;
    w_ro    = 1'b0;
    case (bus.csr_index_i)
      A_MSTATUS:   w_old = w_mstatus;
      A_MISA:      begin w_old = MISA_VAL; w_ro = 1'b1; end
      A_MIE:       w_old = w_mie;
      A_MTVEC:     w_old = w_mtvec;
      A_MSCRATCH:  w_old = r_mscratch;
      A_MEPC:      w_old = r_mepc;
      A_MCAUSE:    w_old = r_mcause;
      A_MTVAL:     w_old = r_mtval;
      A_MIP:       begin w_old = w_mip; w_ro = 1'b1; end
      A_MCYCLE:    w_old = w_cnt[0][31:0];
      A_MCYCLEH:   w_old = w_cnt[0][63:32];
      A_MINSTRET:  w_old = w_cnt[1][31:0];
      A_MINSTRETH: w_old = w_cnt[1][63:32];
      A_MHARTID:   begin w_old = HART_ID; w_ro = 1'b1; end
      default:     w_known = 1'b0;
    endcase
  end

  // RS/RC with a zero operand is a pure read, so it never counts as a write.
  assign w_wr_req  = (bus.csr_op_i == OP_RW) || (bus.csr_op_i[1] && (|bus.csr_src_i));
  assign w_illegal = (bus.csr_op_i != 2'b00) && (!w_known || (w_wr_req && w_ro));

  always_comb begin
    w_wdata = w_old;
    case (bus.csr_op_i)
      OP_RW:   w_wdata = bus.csr_src_i;
      OP_RS:   w_wdata = w_old | bus.csr_src_i;
      OP_RC:   w_wdata = w_old & ~bus.csr_src_i;
      default: w_wdata = w_old;
    endcase
  end

  assign w_irq_pend   = |(w_mip & w_mie);
  assign w_exc        = bus.exc_valid_i && !r_trap;
  assign w_irq_take   = !r_trap && bus.irq_ok_i && r_mstatus_mie && w_irq_pend
                        && !bus.exc_valid_i;
  assign w_mret       = bus.mret_i && !r_trap && !w_exc && !w_irq_take;
  assign w_trap_enter = w_exc || w_irq_take;
  assign w_csr_we     = w_wr_req && !w_illegal && !r_trap && !bus.exc_valid_i
                        && !w_irq_take && !bus.mret_i;

  assign w_irq_cause = (bus.irq_ext_i && r_mie_meie) ? 5'd11 : 5'd7;
  assign w_cause     = w_exc ? bus.exc_cause_i : w_irq_cause;

  always_comb begin
    w_trap_target = {r_mtvec_base, 2'b00};
    if (r_mtvec_vec && w_irq_take && (32'(w_cause) < 32'(NUM_VEC)))
      w_trap_target = {r_mtvec_base, 2'b00} + {25'b0, w_cause, 2'b00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie_mtie     <= 1'b0;
      r_mie_meie     <= 1'b0;
      r_mtvec_base   <= MTVEC_RST[31:2];
      r_mtvec_vec    <= (MTVEC_RST[1:0] == 2'b01);
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
      r_trap         <= 1'b0;
      r_trap_pc      <= '0;
    end else begin
      r_trap <= 1'b0;
      if (w_trap_enter) begin
        r_mepc         <= bus.pc_i & 32'hFFFF_FFFC;
        r_mcause       <= {w_irq_take, 26'b0, w_cause};
        r_mtval        <= w_exc ? bus.exc_tval_i : 32'h0;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
        r_trap         <= 1'b1;
        r_trap_pc      <= w_trap_target;
      end else if (w_mret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
        r_trap         <= 1'b1;
        r_trap_pc      <= r_mepc;
      end else if (w_csr_we) begin
        case (bus.csr_index_i)
          A_MSTATUS: begin
            r_mstatus_mie  <= w_wdata[3];
            r_mstatus_mpie <= w_wdata[7];
          end
          A_MIE: begin
            r_mie_mtie <= w_wdata[7];
            r_mie_meie <= w_wdata[11];
          end
          A_MTVEC: begin
            // Modes 2/3 are reserved and collapse to direct.
            r_mtvec_base <= w_wdata[31:2];
            r_mtvec_vec  <= (w_wdata[1:0] == 2'b01);
          end
          A_MSCRATCH: r_mscratch <= w_wdata;
          A_MEPC:     r_mepc     <= w_wdata & 32'hFFFF_FFFC;
          A_MCAUSE:   r_mcause   <= w_wdata;
          A_MTVAL:    r_mtval    <= w_wdata;
          default:    ;
        endcase
      end
    end
  end

  // Counter 0 is mcycle, counter 1 is minstret.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      localparam logic [11:0] A_LO = (gi == 0) ? A_MCYCLE  : A_MINSTRET;
      localparam logic [11:0] A_HI = (gi == 0) ? A_MCYCLEH : A_MINSTRETH;
      if (CNT_EN != 0) begin : g_on
        logic [63:0] r_cnt;
        logic        w_inc;
        assign w_inc = (gi == 0) ? 1'b1 : bus.retire_i;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_cnt <= '0;
          end else if (w_csr_we && (bus.csr_index_i == A_LO)) begin
            r_cnt[31:0] <= w_wdata;
          end else if (w_csr_we && (bus.csr_index_i == A_HI)) begin
            r_cnt[63:32] <= w_wdata;
          end else if (w_inc) begin
            r_cnt <= r_cnt + 64'd1;
          end
        end
        assign w_cnt[gi] = r_cnt;
      end else begin : g_off
        assign w_cnt[gi] = 64'h0;
      end
    end
  endgenerate

  assign bus.csr_rdata_o = w_illegal ? 32'h0 : w_old;
  assign bus.illegal_o   = w_illegal;
  assign bus.trap_o      = r_trap;
  assign bus.trap_pc_o   = r_trap_pc;
  assign bus.mepc_o      = r_mepc;
  assign bus.irq_pend_o  = w_irq_pend;

endmodule

// File: tb/tb_ysyx_25040101_csr_unit.sv
// Scoreboard bench for the CSR unit: stimulus queues expected CSR read data
// and redirect targets; a negedge monitor pops and compares them.
module tb_ysyx_25040101_csr_unit;

  logic clk;
  logic rst;

  ysyx_25040101_csr_unit_if bus();

  ysyx_25040101_csr_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        chk;
    logic [31:0] rd;
    logic        ill;
  } rd_exp_t;

  rd_exp_t     rd_q[$];
  string       rd_nm_q[$];
  logic [31:0] trap_q[$];
  string       trap_nm_q[$];

  int checks = 0;
  int errors = 0;
  logic prev_trap = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.csr_op_i != 2'b00) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_csr_op got idx=%h none expected", bus.csr_index_i);
        end else begin
          rd_exp_t e;
          string   n;
          e = rd_q.pop_front();
          n = rd_nm_q.pop_front();
          checks++;
          if ((e.chk && bus.csr_rdata_o !== e.rd) || bus.illegal_o !== e.ill) begin
            errors++;
            $display("FAIL %s rdata=%h illegal=%b expected rdata=%h illegal=%b",
                     n, bus.csr_rdata_o, bus.illegal_o, e.rd, e.ill);
          end else begin
            $display("csr %s rdata=%h illegal=%b ok", n, bus.csr_rdata_o, bus.illegal_o);
          end
        end
      end
      if (bus.trap_o === 1'b1) begin
        checks++;
        if (prev_trap) begin
          errors++;
          $display("FAIL trap_back_to_back trap_o high two cycles, expected single pulse");
        end else if (trap_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_trap trap_pc=%h expected no redirect", bus.trap_pc_o);
        end else begin
          logic [31:0] ep;
          string       n;
          ep = trap_q.pop_front();
          n  = trap_nm_q.pop_front();
          if (bus.trap_pc_o !== ep) begin
            errors++;
            $display("FAIL %s trap_pc=%h expected %h", n, bus.trap_pc_o, ep);
          end else begin
            $display("trap %s trap_pc=%h ok", n, bus.trap_pc_o);
          end
        end
      end
      prev_trap = (bus.trap_o === 1'b1);
    end else begin
      prev_trap = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.csr_index_i = 12'h0;
    bus.csr_op_i    = 2'b00;
    bus.csr_src_i   = 32'h0;
    bus.exc_valid_i = 1'b0;
    bus.exc_cause_i = 5'd0;
    bus.exc_tval_i  = 32'h0;
    bus.pc_i        = 32'h0;
    bus.irq_ok_i    = 1'b0;
    bus.mret_i      = 1'b0;
    bus.retire_i    = 1'b0;
  endtask

  task automatic set_csr(input string nm, input logic [11:0] idx, input logic [1:0] op,
                         input logic [31:0] src, input logic chk, input logic [31:0] er,
                         input logic ei);
    rd_exp_t e;
    bus.csr_index_i = idx;
    bus.csr_op_i    = op;
    bus.csr_src_i   = src;
    e.chk = chk;
    e.rd  = er;
    e.ill = ei;
    rd_q.push_back(e);
    rd_nm_q.push_back(nm);
  endtask

  task automatic csr(input string nm, input logic [11:0] idx, input logic [1:0] op,
                     input logic [31:0] src, input logic chk, input logic [31:0] er,
                     input logic ei);
    set_csr(nm, idx, op, src, chk, er, ei);
    tick();
    bus.csr_op_i  = 2'b00;
    bus.csr_src_i = 32'h0;
  endtask

  task automatic rd(input string nm, input logic [11:0] idx, input logic [31:0] er);
    csr(nm, idx, 2'b10, 32'h0, 1'b1, er, 1'b0);
  endtask

  task automatic expect_trap(input string nm, input logic [31:0] pc);
    trap_q.push_back(pc);
    trap_nm_q.push_back(nm);
  endtask

  task automatic inline_chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end else begin
      $display("chk %s value=%h ok", nm, act);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    bus.irq_timer_i = 1'b0;
    bus.irq_ext_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state and RO/illegal handling
    inline_chk("rst_trap_o", 32'(bus.trap_o), 32'h0);
    inline_chk("rst_mepc_o", bus.mepc_o, 32'h0);
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    rd("misa_rs0", 12'h301, 32'h4000_0100);
    rd("rst_mtvec", 12'h305, 32'h0);
    rd("mhartid", 12'hF14, 32'h0);
    csr("unknown_csr", 12'h7C0, 2'b10, 32'h0, 1'b1, 32'h0, 1'b1);
    csr("misa_rw_illegal", 12'h301, 2'b01, 32'h5, 1'b1, 32'h0, 1'b1);
    rd("misa_unchanged", 12'h301, 32'h4000_0100);

    // Direct-mode exception
    csr("mtvec_w", 12'h305, 2'b01, 32'h8000_0000, 1'b1, 32'h0, 1'b0);
    bus.exc_valid_i = 1'b1;
    bus.exc_cause_i = 5'd2;
    bus.pc_i        = 32'h100;
    bus.exc_tval_i  = 32'hDEAD;
    expect_trap("exc_direct", 32'h8000_0000);
    tick();
    idle_all();
    tick();
    rd("exc_mepc", 12'h341, 32'h100);
    rd("exc_mcause", 12'h342, 32'h2);
    rd("exc_mtval", 12'h343, 32'h0000_DEAD);
    rd("exc_mstatus", 12'h300, 32'h0000_1800);

    // Vectored timer interrupt
    csr("mstatus_set_mie", 12'h300, 2'b10, 32'h8, 1'b1, 32'h0000_1800, 1'b0);
    csr("mie_set_mtie", 12'h304, 2'b10, 32'h80, 1'b1, 32'h0, 1'b0);
    csr("mtvec_vec", 12'h305, 2'b01, 32'h8000_0001, 1'b1, 32'h8000_0000, 1'b0);
    bus.irq_timer_i = 1'b1;
    #1;
    inline_chk("irq_pend_timer", 32'(bus.irq_pend_o), 32'h1);
    bus.irq_ok_i = 1'b1;
    bus.pc_i     = 32'h304;
    expect_trap("irq_timer_vec", 32'h8000_001C);
    tick();
    idle_all();
    bus.irq_timer_i = 1'b0;
    tick();
    rd("irq_mcause", 12'h342, 32'h8000_0007);
    rd("irq_mstatus", 12'h300, 32'h0000_1880);
    rd("irq_mepc", 12'h341, 32'h304);
    rd("irq_mtval", 12'h343, 32'h0);

    // Exception + mret + CSR write in one cycle: exception wins
    set_csr("collide_mscratch", 12'h340, 2'b01, 32'h1234, 1'b1, 32'h0, 1'b0);
    bus.exc_valid_i = 1'b1;
    bus.exc_cause_i = 5'd5;
    bus.pc_i        = 32'h400;
    bus.mret_i      = 1'b1;
    expect_trap("collide_exc", 32'h8000_0000);
    tick();
    idle_all();
    tick();
    rd("collide_mscratch_kept", 12'h340, 32'h0);
    rd("collide_mcause", 12'h342, 32'h5);
    rd("collide_mstatus", 12'h300, 32'h0000_1800);

    // mret
    csr("mepc_w", 12'h341, 2'b01, 32'h200, 1'b1, 32'h400, 1'b0);
    csr("mstatus_set_mpie", 12'h300, 2'b10, 32'h80, 1'b1, 32'h0000_1800, 1'b0);
    bus.mret_i = 1'b1;
    expect_trap("mret", 32'h200);
    tick();
    idle_all();
    tick();
    rd("mret_mstatus", 12'h300, 32'h0000_1888);
    inline_chk("mret_mepc_o", bus.mepc_o, 32'h200);
    csr("mstatus_rc_mie", 12'h300, 2'b11, 32'h8, 1'b1, 32'h0000_1888, 1'b0);
    rd("mstatus_after_rc", 12'h300, 32'h0000_1880);

    // External beats timer
    csr("mie_set_meie", 12'h304, 2'b10, 32'h800, 1'b1, 32'h80, 1'b0);
    csr("mstatus_set_mie2", 12'h300, 2'b10, 32'h8, 1'b1, 32'h0000_1880, 1'b0);
    bus.irq_timer_i = 1'b1;
    bus.irq_ext_i   = 1'b1;
    bus.irq_ok_i    = 1'b1;
    bus.pc_i        = 32'h500;
    expect_trap("irq_ext_vec", 32'h8000_002C);
    tick();
    idle_all();
    bus.irq_timer_i = 1'b0;
    bus.irq_ext_i   = 1'b0;
    tick();
    rd("ext_mcause", 12'h342, 32'h8000_000B);
    rd("ext_mepc", 12'h341, 32'h500);
    rd("ext_mstatus", 12'h300, 32'h0000_1880);
    csr("mtvec_mode2", 12'h305, 2'b01, 32'h8000_0002, 1'b1, 32'h8000_0001, 1'b0);
    rd("mtvec_mode2_rb", 12'h305, 32'h8000_0000);

    // Counters
    csr("mcycleh_w0", 12'hB80, 2'b01, 32'h0, 1'b0, 32'h0, 1'b0);
    csr("mcycle_w_max", 12'hB00, 2'b01, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
    tick();
    rd("mcycle_lo_wrap", 12'hB00, 32'h0);
    rd("mcycle_hi_carry", 12'hB80, 32'h1);
    csr("mcycleh_w5", 12'hB80, 2'b01, 32'h5, 1'b1, 32'h1, 1'b0);
    rd("mcycleh_5", 12'hB80, 32'h5);
    csr("minstret_w0", 12'hB02, 2'b01, 32'h0, 1'b1, 32'h0, 1'b0);
    bus.retire_i = 1'b1;
    repeat (3) tick();
    bus.retire_i = 1'b0;
    rd("minstret_3", 12'hB02, 32'h3);

    // Async reset while trap_o is high
    bus.exc_valid_i = 1'b1;
    bus.exc_cause_i = 5'd3;
    bus.pc_i        = 32'h600;
    tick();
    idle_all();
    inline_chk("pre_rst_trap_o", 32'(bus.trap_o), 32'h1);
    rst = 1'b1;
    #1;
    inline_chk("rst_drops_trap", 32'(bus.trap_o), 32'h0);
    tick();
    rst = 1'b0;
    rd("rerst_mstatus", 12'h300, 32'h0000_1800);
    rd("rerst_mtvec", 12'h305, 32'h0);
    rd("rerst_mcycleh", 12'hB80, 32'h0);
    inline_chk("rerst_mepc_o", bus.mepc_o, 32'h0);

    repeat (3) tick();
    inline_chk("rd_queue_drained", 32'(rd_q.size()), 32'h0);
    inline_chk("trap_queue_drained", 32'(trap_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
